// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader: packs fields + immediate into a word,
// buffers it in a 2-entry FIFO and streams it to instruction memory.
// Ports: clk, rst_n (async, active low), clear (sync flush)
//   in_*  : valid/ready field input (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm)
//   mem_* : write port (we/ready handshake, auto-incrementing word address, data)
//   wr_count : completed writes since reset/clear (saturating)
//   err_pulse/err_count : rejected inputs; active only with IMM_RANGE_CHECK_EN defined
module instr_encoder #(
    parameter int                 ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [31:0]     NOP   = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [31:0]       w_word;
    logic              w_ok;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    logic [31:0]       r_buf0;
    logic [31:0]       r_buf1;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_wr_count;

    // ---------------- encode ----------------
    always_comb begin
        w_word = NOP;
        case (in_fmt)
            FMT_I: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:0], in_opcode};
            FMT_B: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
            FMT_J: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
            FMT_U: w_word = {in_imm[31:12], in_rd, in_opcode};
            FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            default: w_word = NOP;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be representable in the field it is packed into.
    always_comb begin
        w_ok = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: w_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            FMT_B: w_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            FMT_J: w_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            FMT_U: w_ok = (in_imm[11:0] == 12'h000);
            FMT_R: w_ok = 1'b1;
            default: w_ok = 1'b0;
        endcase
    end
`else
    assign w_ok = 1'b1;
`endif

    // ---------------- handshakes ----------------
    assign in_ready = !clear && (r_count != 2'd2);
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_ok;
    assign mem_we   = (r_count != 2'd0);
    // clear wins over a same-cycle write completion
    assign w_pop    = mem_we && mem_ready && !clear;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) r_buf1 <= w_word;
                else          r_buf0 <= w_word;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign mem_wdata = r_rd_ptr ? r_buf1 : r_buf0;

    // ---------------- address / write count ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= BASE_ADDR;
            r_wr_count <= '0;
        end else if (clear) begin
            r_addr     <= BASE_ADDR;
            r_wr_count <= '0;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_ONE;
            if (r_wr_count != '1) r_wr_count <= r_wr_count + CNT_ONE;
        end
    end

    assign mem_addr = r_addr;
    assign wr_count = r_wr_count;

    // ---------------- error reporting ----------------
`ifdef IMM_RANGE_CHECK_EN
    logic       r_err_pulse;
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
        end else if (clear) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_accept && !w_ok;
            if (w_accept && !w_ok && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
`else
    assign err_pulse = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=2 to exercise wrap).
// Works with and without IMM_RANGE_CHECK_EN defined.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_fmt = '0;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          mem_we;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   wr_count;
    logic          err_pulse;
    logic [7:0]    err_count;

    int n_chk = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wr_count(wr_count),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Offer one field set; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        step;
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] wc);
        int n;
        mem_ready = 1'b1;
        n = 0;
        while (!mem_we && n < 20) begin
            step;
            n++;
        end
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_addr"}, {30'd0, mem_addr}, a);
        chk({tag, "_data"}, mem_wdata, d);
        step;
        chk({tag, "_wrcnt"}, {29'd0, wr_count}, wc);
    endtask

    initial begin
        // reset
        mem_ready = 1'b1;
        step; step;
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_addr", {30'd0, mem_addr}, 32'd0);
        chk("rst_wrcnt", {29'd0, wr_count}, 32'd0);
        chk("rst_errp", {31'd0, err_pulse}, 32'd0);
        chk("rst_errc", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        step;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // I: addi x1,x0,-1 with latency check
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        #1;
        chk("lat_we_before", {31'd0, mem_we}, 32'd0);
        step;
        in_valid = 1'b0;
        chk("lat_we_after", {31'd0, mem_we}, 32'd1);
        chk("addi_data", mem_wdata, 32'hFFF0_0093);
        chk("addi_addr", {30'd0, mem_addr}, 32'd0);
        step;
        chk("addi_we_off", {31'd0, mem_we}, 32'd0);
        chk("addi_addr_inc", {30'd0, mem_addr}, 32'd1);
        chk("addi_wrcnt", {29'd0, wr_count}, 32'd1);

        // S, B, J, U, R and I boundary; addresses wrap 3 -> 0
        send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_write("sw", 32'd1, 32'h0020_A423, 32'd2);
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        expect_write("beq", 32'd2, 32'hFE00_0EE3, 32'd3);
        send(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        expect_write("jal", 32'd3, 32'h0080_00EF, 32'd4);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_write("lui_wrap", 32'd0, 32'h1234_52B7, 32'd5);
        send(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
        expect_write("sub", 32'd1, 32'h4020_81B3, 32'd6);
        send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_write("addi5", 32'd2, 32'h0050_0113, 32'd7);
        send(3'd0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        expect_write("addi_min_sat", 32'd3, 32'h8000_0193, 32'd7);

        // backpressure: two accepted, third held
        mem_ready = 1'b0;
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        chk("bp_we", {31'd0, mem_we}, 32'd1);
        chk("bp_addr0", {30'd0, mem_addr}, 32'd0);
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        #1;
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        step;
        chk("bp_full2", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_addr", {30'd0, mem_addr}, 32'd0);
        chk("bp_hold_data", mem_wdata, 32'h0010_0093);
        mem_ready = 1'b1;
        step;
        chk("bp_w2_addr", {30'd0, mem_addr}, 32'd1);
        chk("bp_w2_data", mem_wdata, 32'h0020_0093);
        chk("bp_ready", {31'd0, in_ready}, 32'd1);
        step;
        in_valid = 1'b0;
        chk("bp_w3_we", {31'd0, mem_we}, 32'd1);
        chk("bp_w3_addr", {30'd0, mem_addr}, 32'd2);
        chk("bp_w3_data", mem_wdata, 32'h0030_0093);
        step;
        chk("bp_empty", {31'd0, mem_we}, 32'd0);
        chk("bp_addr3", {30'd0, mem_addr}, 32'd3);

        // clear with a pending word, same-cycle write and push
        mem_ready = 1'b0;
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        chk("clr_pend", {31'd0, mem_we}, 32'd1);
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        mem_ready = 1'b1;
        clear = 1'b1;
        #1;
        chk("clr_ready", {31'd0, in_ready}, 32'd0);
        step;
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_we", {31'd0, mem_we}, 32'd0);
        chk("clr_addr", {30'd0, mem_addr}, 32'd0);
        chk("clr_wrcnt", {29'd0, wr_count}, 32'd0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_write("clr_lui", 32'd0, 32'h1234_52B7, 32'd1);

        // range: misaligned branch and illegal format
`ifdef IMM_RANGE_CHECK_EN
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("rng_errp", {31'd0, err_pulse}, 32'd1);
        chk("rng_errc", {24'd0, err_count}, 32'd1);
        chk("rng_nowe", {31'd0, mem_we}, 32'd0);
        step;
        chk("rng_errp_off", {31'd0, err_pulse}, 32'd0);
        chk("rng_nowe2", {31'd0, mem_we}, 32'd0);
        send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        chk("ill_errp", {31'd0, err_pulse}, 32'd1);
        chk("ill_errc", {24'd0, err_count}, 32'd2);
        chk("ill_nowe", {31'd0, mem_we}, 32'd0);
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        expect_write("beq4", 32'd1, 32'h0000_0263, 32'd2);
`else
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("rng_errp", {31'd0, err_pulse}, 32'd0);
        expect_write("beq_odd", 32'd1, 32'h0000_0163, 32'd2);
        send(3'd7, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF);
        expect_write("ill_nop", 32'd2, 32'h0000_0013, 32'd3);
        chk("noerr_cnt", {24'd0, err_count}, 32'd0);
`endif

        // reset mid-stream drops the pending word
        mem_ready = 1'b0;
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        chk("mrst_pend", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_we", {31'd0, mem_we}, 32'd0);
        chk("mrst_addr", {30'd0, mem_addr}, 32'd0);
        chk("mrst_wrcnt", {29'd0, wr_count}, 32'd0);
        chk("mrst_wdata", mem_wdata, 32'd0);
        chk("mrst_errc", {24'd0, err_count}, 32'd0);
        step;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step;
        chk("mrst_idle", {31'd0, mem_we}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
